ah_route_sel_258_12: RTL and testbench

- Ingress stage that sits directly upstream of the 258-bit, 12-way valid/ready demux.
- Accepts 258-bit beats and decodes the destination port from the first beat of each packet.
- Holds that select for every beat of the packet and presents the beat, its valid and a 4-bit select to the demux.
- Uses a registered 2-entry skid buffer, so both directions are timing-isolated at full throughput.

---
 rtl/ah_route_sel_258_12.sv | 145 ++++++++++++++
 tb/tb_ah_route_sel_258_12.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ah_route_sel_258_12.sv
// Ingress route-select stage ahead of the 258-bit 12-way demux: decodes the
// destination from each packet's FIRST beat and carries it with every beat through a 2-entry skid buffer.
module ah_route_sel_258_12 #(
  parameter int DW        = 258,
  parameter int NUM_EGR   = 12,
  parameter int DFLT_PORT = 0,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   ing_data,
  input  logic            ing_valid,
  output logic            ing_ready,
  output logic [DW-1:0]   egr_data,
  output logic            egr_valid,
  input  logic            egr_ready,
  output logic [3:0]      egr_sel,
  output logic [CNTW-1:0] err_cnt
);

  localparam logic [4:0] NUM_EGR_W = 5'(NUM_EGR);
  localparam logic [3:0] DFLT_SEL  = 4'(DFLT_PORT);

  typedef enum logic {IDLE, PKT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      held_sel;
  logic            first, last;
  logic [3:0]      dest;
  logic [3:0]      sel_dec;
  logic [1:0]      err_inc;
  logic            push, pop;
  logic [1:0]      occ, occ_nxt;
  logic            ready_q;
  logic [DW-1:0]   data0, data1;
  logic [3:0]      sel0, sel1;
  logic [CNTW:0]   err_sum;

  assign first = ing_data[DW-2];
  assign last  = ing_data[DW-1];
  assign dest  = ing_data[3:0];

  assign push = ing_valid & ready_q;
  assign pop  = (occ != 2'd0) & egr_ready;

  // Decode FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      held_sel <= '0;
    end else if (push) begin
      state    <= state_nxt;
      held_sel <= sel_dec;
    end
  end

  // Decode FSM: next state
  always_comb begin
    state_nxt = state;
    if (first) begin
      state_nxt = last ? IDLE : PKT;
    end else if (state == PKT && last) begin
      state_nxt = IDLE;
    end
  end

  // Decode FSM: select and error outputs; a FIRST in PKT is a restart and
  // can stack with an illegal destination for +2.
  always_comb begin
    sel_dec = DFLT_SEL;
    err_inc = '0;
    if (first) begin
      if ({1'b0, dest} < NUM_EGR_W) begin
        sel_dec = dest;
      end else begin
        err_inc = err_inc + 2'd1;
      end
      if (state == PKT) begin
        err_inc = err_inc + 2'd1;
      end
    end else if (state == PKT) begin
      sel_dec = held_sel;
    end else begin
      err_inc = 2'd1;
    end
  end

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Skid buffer: entry 0 always drives egress, entry 1 absorbs the beat
  // accepted while egress is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= '0;
      ready_q <= 1'b1;
      data0   <= '0;
      data1   <= '0;
      sel0    <= '0;
      sel1    <= '0;
    end else begin
      occ     <= occ_nxt;
      ready_q <= (occ_nxt != 2'd2);
      if (pop) begin
        if (occ == 2'd2) begin
          data0 <= data1;
          sel0  <= sel1;
        end else if (push) begin
          data0 <= ing_data;
          sel0  <= sel_dec;
        end
      end else if (push) begin
        if (occ == 2'd0) begin
          data0 <= ing_data;
          sel0  <= sel_dec;
        end else begin
          data1 <= ing_data;
          sel1  <= sel_dec;
        end
      end
    end
  end

  assign err_sum = {1'b0, err_cnt} + (CNTW+1)'(err_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (push && err_inc != 2'd0) begin
      err_cnt <= err_sum[CNTW] ? '1 : err_sum[CNTW-1:0];
    end
  end

  assign ing_ready = ready_q;
  assign egr_valid = (occ != 2'd0);
  assign egr_data  = data0;
  assign egr_sel   = sel0;

endmodule

// File: tb/tb_ah_route_sel_258_12.sv
// Directed bench for ah_route_sel_258_12: decode, hold, backpressure, error
// counting and mid-packet reset, all with hand-computed expectations.
module tb_ah_route_sel_258_12;

  logic         clk = 1'b0;
  logic         rst;
  logic [257:0] ing_data;
  logic         ing_valid;
  logic         ing_ready;
  logic [257:0] egr_data;
  logic         egr_valid;
  logic         egr_ready;
  logic [3:0]   egr_sel;
  logic [15:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  ah_route_sel_258_12 #(.DW(258), .NUM_EGR(12), .DFLT_PORT(0), .CNTW(16)) dut (
    .clk(clk), .rst(rst),
    .ing_data(ing_data), .ing_valid(ing_valid), .ing_ready(ing_ready),
    .egr_data(egr_data), .egr_valid(egr_valid), .egr_ready(egr_ready),
    .egr_sel(egr_sel), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [257:0] mk(input logic f, input logic l, input logic [3:0] d,
                                      input logic [31:0] p);
    logic [257:0] b;
    b = '0;
    b[257] = l;
    b[256] = f;
    b[255:224] = ~p;
    b[35:4] = p;
    b[3:0] = d;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ing_valid = 1'b0; ing_data = '0; egr_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ing_valid = 1'b0; ing_data = '0; egr_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (egr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", egr_valid); end
    checks++; if (egr_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", egr_data); end
    checks++; if (egr_sel !== 4'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", egr_sel); end
    checks++; if (ing_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ing_ready); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_single();
    logic [257:0] b;
    b = mk(1'b1, 1'b1, 4'd5, 32'hA1A1_0001);
    egr_ready = 1'b1; ing_data = b; ing_valid = 1'b1;
    tick();
    ing_valid = 1'b0;
    checks++; if (egr_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", egr_valid); end
    checks++; if (egr_sel !== 4'd5) begin failures++; $display("FAIL single_sel got=%0d exp=5", egr_sel); end
    checks++; if (egr_data !== b) begin failures++; $display("FAIL single_data got=%h exp=%h", egr_data, b); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL single_err got=%0d exp=0", err_cnt); end
    tick();
    checks++; if (egr_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", egr_valid); end
  endtask

  task automatic test_back_to_back();
    logic [257:0] beats [7];
    logic [3:0]   exp_sel [7];
    beats[0] = mk(1'b1, 1'b0, 4'd9, 32'h0900_0000);
    beats[1] = mk(1'b0, 1'b0, 4'hF, 32'h0900_0001);
    beats[2] = mk(1'b0, 1'b0, 4'h3, 32'h0900_0002);
    beats[3] = mk(1'b0, 1'b1, 4'hE, 32'h0900_0003);
    beats[4] = mk(1'b1, 1'b0, 4'd2, 32'h0200_0000);
    beats[5] = mk(1'b0, 1'b0, 4'hD, 32'h0200_0001);
    beats[6] = mk(1'b0, 1'b1, 4'h0, 32'h0200_0002);
    exp_sel = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd2, 4'd2, 4'd2};
    egr_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ing_data = beats[i]; ing_valid = 1'b1;
      tick();
      checks++; if (egr_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, egr_valid); end
      checks++; if (egr_sel !== exp_sel[i]) begin failures++; $display("FAIL b2b_sel[%0d] got=%0d exp=%0d", i, egr_sel, exp_sel[i]); end
      checks++; if (egr_data !== beats[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, egr_data, beats[i]); end
      checks++; if (ing_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, ing_ready); end
    end
    ing_valid = 1'b0;
    tick();
    checks++; if (egr_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", egr_valid); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [257:0] beats [6];
    int acc, rx;
    beats[0] = mk(1'b1, 1'b0, 4'd4, 32'h4400_0000);
    for (int i = 1; i < 5; i++) beats[i] = mk(1'b0, 1'b0, 4'(i), 32'h4400_0000 + 32'(i));
    beats[5] = mk(1'b0, 1'b1, 4'h7, 32'h4400_0005);
    acc = 0; rx = 0;
    egr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (ing_ready !== (c < 2)) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=%b", c, ing_ready, (c < 2)); end
      ing_data = beats[acc]; ing_valid = 1'b1;
      if (c < 2) acc++;
      tick();
      checks++; if (egr_valid !== 1'b1 || egr_data !== beats[0] || egr_sel !== 4'd4) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%0d exp=1/4 data_ok=%b", c, egr_valid, egr_sel, egr_data === beats[0]);
      end
    end
    egr_ready = 1'b1;
    for (int c = 0; c < 20 && rx < 6; c++) begin
      if (egr_valid === 1'b1) begin
        checks++; if (egr_data !== beats[rx] || egr_sel !== 4'd4) begin
          failures++; $display("FAIL bp_order[%0d] got_sel=%0d exp_sel=4 got=%h exp=%h", rx, egr_sel, egr_data, beats[rx]);
        end
        rx++;
      end
      if (acc < 6) begin
        ing_data = beats[acc]; ing_valid = 1'b1;
        if (ing_ready === 1'b1) acc++;
      end else begin
        ing_valid = 1'b0;
      end
      tick();
    end
    ing_valid = 1'b0;
    checks++; if (rx != 6 || acc != 6) begin failures++; $display("FAIL bp_count got_rx=%0d got_acc=%0d exp=6/6", rx, acc); end
    tick();
    checks++; if (egr_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", egr_valid); end
  endtask

  task automatic send(input logic [257:0] b);
    ing_data = b; ing_valid = 1'b1;
    tick();
    ing_valid = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    egr_ready = 1'b1;
    send(mk(1'b1, 1'b1, 4'd13, 32'hE0));
    checks++; if (egr_sel !== 4'd0 || err_cnt !== 16'd1) begin failures++; $display("FAIL illegal_dest got=%0d/%0d exp=0/1", egr_sel, err_cnt); end
    send(mk(1'b0, 1'b0, 4'd7, 32'hE1));
    checks++; if (egr_sel !== 4'd0 || err_cnt !== 16'd2) begin failures++; $display("FAIL orphan got=%0d/%0d exp=0/2", egr_sel, err_cnt); end
    send(mk(1'b1, 1'b1, 4'd11, 32'hE2));
    checks++; if (egr_sel !== 4'd11 || err_cnt !== 16'd2) begin failures++; $display("FAIL dest_max got=%0d/%0d exp=11/2", egr_sel, err_cnt); end
    send(mk(1'b1, 1'b1, 4'd12, 32'hE3));
    checks++; if (egr_sel !== 4'd0 || err_cnt !== 16'd3) begin failures++; $display("FAIL dest_12 got=%0d/%0d exp=0/3", egr_sel, err_cnt); end
  endtask

  task automatic test_missing_last();
    logic [3:0] exp_sel [3];
    logic [257:0] beats [3];
    beats[0] = mk(1'b1, 1'b0, 4'd3, 32'hF0);
    beats[1] = mk(1'b0, 1'b0, 4'hB, 32'hF1);
    beats[2] = mk(1'b1, 1'b1, 4'd7, 32'hF2);
    exp_sel = '{4'd3, 4'd3, 4'd7};
    for (int i = 0; i < 3; i++) begin
      send(beats[i]);
      checks++; if (egr_sel !== exp_sel[i] || egr_data !== beats[i]) begin
        failures++; $display("FAIL miss_last_sel[%0d] got=%0d exp=%0d", i, egr_sel, exp_sel[i]);
      end
    end
    checks++; if (err_cnt !== 16'd4) begin failures++; $display("FAIL miss_last_err got=%0d exp=4", err_cnt); end
    send(mk(1'b1, 1'b0, 4'd3, 32'hF3));
    send(mk(1'b1, 1'b1, 4'd14, 32'hF4));
    checks++; if (egr_sel !== 4'd0 || err_cnt !== 16'd6) begin failures++; $display("FAIL double_err got=%0d/%0d exp=0/6", egr_sel, err_cnt); end
  endtask

  task automatic test_reset_mid();
    egr_ready = 1'b0;
    send(mk(1'b1, 1'b0, 4'd6, 32'hC0));
    send(mk(1'b0, 1'b0, 4'hF, 32'hC1));
    checks++; if (egr_valid !== 1'b1 || ing_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%b/%b exp=1/0", egr_valid, ing_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (egr_valid !== 1'b0 || err_cnt !== 16'd0 || ing_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/1", egr_valid, err_cnt, ing_ready);
    end
    egr_ready = 1'b1;
    send(mk(1'b0, 1'b1, 4'hF, 32'hC2));
    checks++; if (egr_valid !== 1'b1 || egr_sel !== 4'd0 || err_cnt !== 16'd1) begin
      failures++; $display("FAIL mid_orphan got=%b/%0d/%0d exp=1/0/1", egr_valid, egr_sel, err_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ing_valid = 1'b0; ing_data = '0; egr_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_missing_last();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
